// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared definitions for the AES-128 key schedule sequencing controller:
// state encoding and key geometry constants.
package aes_key_schedule_ctrl_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_COLS   = 4;
  localparam int ROUND_W    = 4;
  localparam int COL_W      = $clog2(NUM_COLS);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HOLD    = 3'd1;
  localparam state_t ST_SB_SEND = 3'd2;
  localparam state_t ST_SB_WAIT = 3'd3;
  localparam state_t ST_UPD0    = 3'd4;
  localparam state_t ST_UPD1    = 3'd5;
  localparam state_t ST_UPD2    = 3'd6;
  localparam state_t ST_UPD3    = 3'd7;

endpackage

// File: rtl/aes_key_sb_wait_cnt.sv
// Loadable down-counter used to wait out the S-box pipeline latency.
// Saturates at zero; `zero` flags the terminal count.
module aes_key_sb_wait_cnt
  import aes_key_schedule_ctrl_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Sequencing controller for the masked 32-bit AES-128 key datapath: key load,
// column rotation and round-key update. Optional `abort` input: KEYCTRL_ABORT_EN.
module aes_key_schedule_ctrl
  import aes_key_schedule_ctrl_pkg::*;
#(
  parameter int SB_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef KEYCTRL_ABORT_EN
  input  logic               abort,
`endif
  input  logic               key_valid,
  output logic               key_ready,
  input  logic               ak_valid,
  output logic               ak_ready,
  input  logic               upd_valid,
  output logic               upd_ready,
  output logic               upd_done,
  output logic               sb_valid,
  output logic               init,
  output logic               enable,
  output logic               loop,
  output logic               add_from_sb,
  output logic               rcon_rst,
  output logic               rcon_update,
  output logic [ROUND_W-1:0] round,
  output logic [COL_W-1:0]   col,
  output logic               last_round
);

  localparam int CNT_W     = $clog2(SB_LAT + 1);
  // SB_SEND accounts for one latency cycle, SB_WAIT's exit cycle for another.
  localparam int WAIT_INIT = (SB_LAT >= 2) ? (SB_LAT - 2) : 0;

  state_t               state_q, state_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 done_q, done_d;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic                 key_acc, ak_acc, upd_acc;
  logic                 abort_w;

`ifdef KEYCTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  aes_key_sb_wait_cnt #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_INIT)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    col_d    = col_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (abort_w) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (key_acc) begin
            state_d = ST_HOLD;
            round_d = '0;
            col_d   = '0;
          end else if (ak_acc) begin
            col_d = col_q + COL_W'(1);
          end else if (upd_acc) begin
            state_d = ST_SB_SEND;
          end
        end
        ST_SB_SEND: begin
          cnt_load = 1'b1;
          state_d  = (SB_LAT == 1) ? ST_UPD0 : ST_SB_WAIT;
        end
        ST_SB_WAIT: begin
          if (cnt_zero) begin
            state_d = ST_UPD0;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_UPD0: state_d = ST_UPD1;
        ST_UPD1: state_d = ST_UPD2;
        ST_UPD2: state_d = ST_UPD3;
        ST_UPD3: begin
          state_d = ST_HOLD;
          round_d = round_q + ROUND_W'(1);
          col_d   = '0;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reset and abort both silence everything but the rcon reset.
  always_comb begin
    key_ready   = 1'b0;
    ak_ready    = 1'b0;
    upd_ready   = 1'b0;
    upd_done    = 1'b0;
    sb_valid    = 1'b0;
    init        = 1'b0;
    enable      = 1'b0;
    loop        = 1'b0;
    add_from_sb = 1'b0;
    rcon_rst    = 1'b0;
    rcon_update = 1'b0;
    if (rst || abort_w) begin
      rcon_rst = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          key_ready = 1'b1;
          if (key_valid) begin
            init     = 1'b1;
            enable   = 1'b1;
            rcon_rst = 1'b1;
          end
        end
        ST_HOLD: begin
          key_ready = 1'b1;
          upd_done  = done_q;
          ak_ready  = !key_valid;
          upd_ready = !key_valid && !ak_valid && (col_q == '0) &&
                      (round_q < ROUND_W'(NUM_ROUNDS));
          if (key_valid) begin
            init     = 1'b1;
            enable   = 1'b1;
            rcon_rst = 1'b1;
          end else if (ak_valid) begin
            loop   = 1'b1;
            enable = 1'b1;
          end
        end
        ST_SB_SEND: sb_valid = 1'b1;
        ST_UPD0: begin
          enable      = 1'b1;
          add_from_sb = 1'b1;
          rcon_update = 1'b1;
        end
        ST_UPD1, ST_UPD2, ST_UPD3: enable = 1'b1;
        default: ;
      endcase
    end
  end

  assign key_acc = key_ready && key_valid;
  assign ak_acc  = ak_ready && ak_valid;
  assign upd_acc = upd_ready && upd_valid;

  assign round      = rst ? '0 : round_q;
  assign col        = rst ? '0 : col_q;
  assign last_round = (round == ROUND_W'(NUM_ROUNDS));

endmodule

// File: doc/aes_key_schedule_ctrl.md
# aes_key_schedule_ctrl

Sequencing controller for the masked 32-bit AES-128 key datapath. It drives that datapath's control inputs (`init`, `enable`, `loop`, `add_from_sb`, `rcon_rst`, `rcon_update`) through three activities:
- loading a fresh shared key;
- rotating the held round key one column at a time so the cipher core can consume it;
- computing the next round key through the shared S-box.

It sits between the top-level AES FSM and the key datapath, and exposes simple valid/ready handshakes upward.

## Interface
Parameters:
- `SB_LAT`, default 4: S-box pipeline latency in cycles, from `sb_valid` to the result at `sh_4bytes_from_SB`. Legal range is ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  a new shared key is present on the datapath `sh_key`.
- `key_ready`  out  1  a key load can be accepted.
- `ak_valid`  in  1  the core requests a one-column rotation of the held key.
- `ak_ready`  out  1  a rotation can be accepted.
- `upd_valid`  in  1  the core requests computation of the next round key.
- `upd_ready`  out  1  an update can be accepted.
- `upd_done`  out  1  one-cycle pulse: the new round key is held.
- `sb_valid`  out  1  the rotated key column is presented to the S-box this cycle.
- `init`, `enable`, `loop`, `add_from_sb`, `rcon_rst`, `rcon_update`  out  1 each  key datapath controls.
- `round`  out  4  index of the currently held round key, 0..10.
- `col`  out  2  number of columns rotated since the key was last aligned.
- `last_round`  out  1  `round == 10`.

## Operation
States: `IDLE`, `HOLD`, `SB_SEND`, `SB_WAIT`, `UPD0`, `UPD1`, `UPD2`, `UPD3`.

- **IDLE**
  - `key_ready = 1`.
  - On `key_valid`: drive `init = 1`, `enable = 1`, `rcon_rst = 1` for that cycle. This is a parallel load of all 16 bytes.
  - Then set `round = 0`, `col = 0`, and go to `HOLD`.
- **HOLD**
  - `key_ready = 1`. A key handshake reloads exactly as in `IDLE` and has priority over `ak` and `upd`.
  - `ak_ready = !key_valid`.
  - On an `ak` handshake: `loop = 1`, `enable = 1`, and `col` increments mod 4. The key contents are preserved after 4 steps.
  - `upd_ready = !key_valid && !ak_valid && col == 0 && round < 10`. On an `upd` handshake, go to `SB_SEND`.
  - Simultaneous `ak_valid` and `upd_valid`: only `ak` is accepted.
  - Requests are not sticky.
- **SB_SEND**
  - `sb_valid = 1` for exactly one cycle; `enable = 0`.
  - If `SB_LAT == 1`, next state is `UPD0`; otherwise `SB_WAIT`.
- **SB_WAIT**
  - Down-counter waits `SB_LAT - 1` cycles; `enable = 0`.
  - Go to `UPD0` when the counter reaches 0.
- **UPD0**
  - `enable = 1`, `add_from_sb = 1`, `rcon_update = 1`.
  - Computes w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon. The rcon value is the one held before the update.
- **UPD1..UPD3**
  - `enable = 1`, `add_from_sb = 0`, `loop = 0`, `init = 0`.
  - Computes wk' = wk ^ wk-1'.
  - After `UPD3`: `round` increments, `col = 0`, go to `HOLD`, and `upd_done = 1` during the first `HOLD` cycle.
- **Busy behaviour:** in `SB_SEND`, `SB_WAIT` and `UPD*`, all ready signals are 0 and `key_valid` is ignored.
- **Control decode:** all control outputs are combinational decodes of state and accepted handshakes. Control outputs that a state does not list are 0.

## Timing
- **During `rst`:** state becomes `IDLE`; `round = 0`, `col = 0`.
  - All outputs are 0, except `rcon_rst = 1`, which resets the rcon unit concurrently.
- **First cycle after `rst` deasserts:** `key_ready = 1`.
- **Key load:** handshake at cycle t; the key is valid in the registers at t+1, with `round = 0`.
- **Column rotation:** handshake at t; the rotated key is visible at t+1. Back-to-back rotations are allowed every cycle.
- **Round-key update:** handshake at t.
  - `sb_valid` at t+1.
  - `UPD0` at t+1+`SB_LAT`.
  - `UPD3` at t+4+`SB_LAT`.
  - `upd_done` and the new key at t+5+`SB_LAT`.
  - Total latency is `SB_LAT` + 5.
- **Reset mid-update:** immediate return to `IDLE`. The datapath contents become don't-care.
- **Round limit:** at `round == 10`, `upd_ready = 0`; `ak` and reload remain available.

## Configuration
- `KEYCTRL_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort` high in any state forces `IDLE` at the next edge, with `rcon_rst = 1` and all other controls 0 in that cycle. `abort` has lower priority than `rst`.
- Undefined: the `abort` port does not exist, and only `rst` leaves non-`IDLE` states early.

## Structure
- **Shared package/header:**
  - state encoding localparams;
  - `NUM_ROUNDS = 10`;
  - `NUM_COLS = 4`.
- **One sub-module:** `aes_key_sb_wait_cnt`.
  - Loadable down-counter of width clog2(`SB_LAT`+1).
  - Interface: `load`, `zero`.
  - Used for `SB_WAIT` and reusable by the state-datapath controller.

## Test plan
- **Reset/load:** `rst` for 2 cycles, then `key_valid` at cycle 3 → `init = enable = rcon_rst = 1` at cycle 3; `round = 0` and `key_ready = 1` at cycle 4.
- **Full schedule:** load the FIPS-197 key 2b7e1516…, then 10 `upd` requests with `SB_LAT = 4` → `upd_done` 9 cycles after each accept. Round-10 key equals d014f9a8c9ee2589e13f0cc8b6630ca6 after unmasking; `last_round = 1`, `upd_ready = 0`.
- **Rotation:** 4 `ak` steps in consecutive cycles → `col` goes 1, 2, 3, 0; key unchanged after the fourth step; `upd_ready = 1` only at `col = 0`.
- **Contention:** `ak_valid`, `upd_valid` and `key_valid` all high in `HOLD` → only the load occurs; `ak_ready = upd_ready = 0`.
- **Reset mid-update:** `rst` during `SB_WAIT` → next cycle `IDLE`, `sb_valid = enable = 0`, `round = 0`.
- **Abort (`KEYCTRL_ABORT_EN`):** `abort` in `UPD2` → `IDLE` next cycle; `rcon_rst = 1` in the abort cycle; no `upd_done`.
